// File: rtl/systolic_skew_feeder_if.sv
// Start/operand/edge bundle between the job source and the skew feeder.
// Master side issues jobs; slave side drives the array edges.
interface systolic_skew_feeder_if #(
  parameter int WIDTHx = 5,
  parameter int SIZE   = 3
);
  logic start;
  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_input;
  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] b_input;
  logic busy;
  logic acc_clear;
  logic [SIZE-1:0][WIDTHx-1:0] a_edge;
  logic [SIZE-1:0][WIDTHx-1:0] b_edge;
  logic edge_valid;
  logic done;

  modport master (
    output start, a_input, b_input,
    input  busy, acc_clear, a_edge, b_edge,
    input  edge_valid, done
  );

  modport slave (
    input  start, a_input, b_input,
    output busy, acc_clear, a_edge, b_edge,
    output edge_valid, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Captures two operand matrices and feeds them diagonally skewed
// into a systolic array, then drains and flags completion.
module systolic_skew_feeder #(
  parameter int WIDTHx       = 5,
  parameter int SIZE         = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clock,
  input  logic nreset,
  systolic_skew_feeder_if.slave bus
);
  localparam int LAST = 2 * SIZE - 2;
  localparam int SW   = $clog2(2 * SIZE - 1);
  localparam int DW   = (DRAIN_CYCLES > 1) ?
                        $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, FEED, DRAIN, DONE
  } state_t;

  typedef logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] mat_t;
  typedef logic [SIZE-1:0][WIDTHx-1:0] vec_t;

  state_t        state;
  logic [SW-1:0] step;
  logic [SW-1:0] next_t;
  logic [DW-1:0] dcnt;
  mat_t          a_mat;
  mat_t          b_mat;
  vec_t          a_nxt;
  vec_t          b_nxt;

  // Edge values for the step about to be presented; element (i,j)
  // enters the array on the diagonal where i + j equals the step.
  always_comb begin
    next_t = (state == FEED) ? step + SW'(1) : '0;
    a_nxt  = '0;
    b_nxt  = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (int'(next_t) == i + j) begin
          a_nxt[i] = a_mat[i][j];
          b_nxt[j] = b_mat[i][j];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      step           <= '0;
      dcnt           <= '0;
      a_mat          <= '0;
      b_mat          <= '0;
      bus.busy       <= 1'b0;
      bus.acc_clear  <= 1'b0;
      bus.edge_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.a_edge     <= '0;
      bus.b_edge     <= '0;
    end else begin
      bus.acc_clear <= 1'b0;
      bus.done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_mat         <= bus.a_input;
            b_mat         <= bus.b_input;
            state         <= LOAD;
            bus.busy      <= 1'b1;
            bus.acc_clear <= 1'b1;
          end
        end
        LOAD: begin
          state          <= FEED;
          step           <= '0;
          bus.edge_valid <= 1'b1;
          bus.a_edge     <= a_nxt;
          bus.b_edge     <= b_nxt;
        end
        FEED: begin
          if (step == SW'(LAST)) begin
            state          <= DRAIN;
            step           <= '0;
            dcnt           <= '0;
            bus.edge_valid <= 1'b0;
            bus.a_edge     <= '0;
            bus.b_edge     <= '0;
          end else begin
            step       <= next_t;
            bus.a_edge <= a_nxt;
            bus.b_edge <= b_nxt;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
